// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
// Opcode constants let decode-side logic classify long-latency writers consistently.
package id_hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int CNT_W      = 32;

  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_R32        = 7'b0110011;
  localparam logic [6:0] OP_R64        = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Individual stall causes, kept separate so they are easy to probe in a waveform.
  typedef struct packed {
    logic raw_rs1;
    logic raw_rs2;
    logic waw_rd;
    logic mul_busy;
  } hazard_t;

endpackage

// File: rtl/id_hazard_scoreboard_sb_sat_counter.sv
// Saturating up-counter with enable; holds at all ones instead of wrapping.
// Generic enough to back any performance counter in the pipeline.
module sb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage scoreboard: tracks pending rd of loads and mul/div ops, stalls
// decode on RAW/WAW hazards or a busy mul/div unit, and counts stalled cycles.
module id_hazard_scoreboard #(
  parameter int REG_NUM    = id_hazard_scoreboard_pkg::REG_NUM,
  parameter int REG_ADDR_W = id_hazard_scoreboard_pkg::REG_ADDR_W,
  parameter int CNT_W      = id_hazard_scoreboard_pkg::CNT_W
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  IdValid,
  input  logic [REG_ADDR_W-1:0] IdRs1Addr,
  input  logic                  IdRs1ReadEnable,
  input  logic [REG_ADDR_W-1:0] IdRs2Addr,
  input  logic                  IdRs2ReadEnable,
  input  logic [REG_ADDR_W-1:0] IdRdAddr,
  input  logic                  IdIsLoad,
  input  logic                  IdIsMulDiv,
  input  logic                  Flush,
  input  logic                  LoadDoneValid,
  input  logic [REG_ADDR_W-1:0] LoadDoneAddr,
  input  logic                  MulDoneValid,
  input  logic [REG_ADDR_W-1:0] MulDoneAddr,
  output logic                  StallId,
  output logic                  BubbleOut,
  output logic                  MulBusy,
  output logic [REG_NUM-1:0]    PendingOut,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  SbError
);
  import id_hazard_scoreboard_pkg::*;

  logic [REG_NUM-1:0] pending_q, pending_d;
  logic [REG_NUM-1:0] clr_vec, set_vec, avail_vec;
  logic               mul_busy_q, mul_busy_d;
  logic               sb_error_q, sb_error_d;
  hazard_t            haz;
  logic               hazard, issue, writer;

  // A register retiring this cycle is already usable: Ex forwards the writeback.
  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_clr
    assign clr_vec[gi] = (LoadDoneValid && (LoadDoneAddr == REG_ADDR_W'(gi))) ||
                         (MulDoneValid  && (MulDoneAddr  == REG_ADDR_W'(gi)));
  end

  assign avail_vec = pending_q & ~clr_vec;
  assign writer    = IdIsLoad || IdIsMulDiv;

  always_comb begin
    haz.raw_rs1  = IdRs1ReadEnable && (IdRs1Addr != '0) && avail_vec[IdRs1Addr];
    haz.raw_rs2  = IdRs2ReadEnable && (IdRs2Addr != '0) && avail_vec[IdRs2Addr];
    haz.waw_rd   = writer && (IdRdAddr != '0) && avail_vec[IdRdAddr];
    haz.mul_busy = IdIsMulDiv && mul_busy_q && !MulDoneValid;
    hazard       = IdValid && !Flush && (|haz);
    issue        = IdValid && !Flush && !hazard;
  end

  always_comb begin
    set_vec = '0;
    if (issue && writer && (IdRdAddr != '0)) begin
      set_vec[IdRdAddr] = 1'b1;
    end
    // Set is applied after clear so a younger writer to the same rd wins.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;

    mul_busy_d = mul_busy_q;
    if (issue && IdIsMulDiv) begin
      mul_busy_d = 1'b1;
    end else if (MulDoneValid) begin
      mul_busy_d = 1'b0;
    end

    sb_error_d = sb_error_q ||
                 (LoadDoneValid && !pending_q[LoadDoneAddr]) ||
                 (MulDoneValid  && !pending_q[MulDoneAddr]);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pending_q  <= '0;
      mul_busy_q <= 1'b0;
      sb_error_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mul_busy_q <= mul_busy_d;
      sb_error_q <= sb_error_d;
    end
  end

  sb_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .en    (hazard),
    .cnt   (StallCount)
  );

  assign StallId    = hazard;
  assign BubbleOut  = hazard;
  assign MulBusy    = mul_busy_q;
  assign PendingOut = pending_q;
  assign SbError    = sb_error_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed and randomized bench for id_hazard_scoreboard against a set-based reference model.
module tb_id_hazard_scoreboard;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IdValid, IdRs1ReadEnable, IdRs2ReadEnable, IdIsLoad, IdIsMulDiv, Flush;
  logic [4:0]  IdRs1Addr, IdRs2Addr, IdRdAddr, LoadDoneAddr, MulDoneAddr;
  logic        LoadDoneValid, MulDoneValid;
  logic        StallId, BubbleOut, MulBusy, SbError;
  logic [31:0] PendingOut, StallCount;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of in-flight destination registers plus scalar flags.
  bit      m_pend[32];
  bit      m_busy;
  bit      m_err;
  longint  m_cnt;
  bit      m_haz;

  id_hazard_scoreboard dut (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid),
    .IdRs1Addr(IdRs1Addr), .IdRs1ReadEnable(IdRs1ReadEnable),
    .IdRs2Addr(IdRs2Addr), .IdRs2ReadEnable(IdRs2ReadEnable),
    .IdRdAddr(IdRdAddr), .IdIsLoad(IdIsLoad), .IdIsMulDiv(IdIsMulDiv), .Flush(Flush),
    .LoadDoneValid(LoadDoneValid), .LoadDoneAddr(LoadDoneAddr),
    .MulDoneValid(MulDoneValid), .MulDoneAddr(MulDoneAddr),
    .StallId(StallId), .BubbleOut(BubbleOut), .MulBusy(MulBusy),
    .PendingOut(PendingOut), .StallCount(StallCount), .SbError(SbError)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic bit retiring(input int r);
    return (LoadDoneValid && int'(LoadDoneAddr) == r) || (MulDoneValid && int'(MulDoneAddr) == r);
  endfunction

  function automatic bit blocked(input int r);
    return (r != 0) && m_pend[r] && !retiring(r);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_busy = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic drive(input bit v, input int rs1, input bit r1e, input int rs2, input bit r2e,
                       input int rd, input bit ld, input bit md, input bit fl,
                       input bit ldv, input int lda, input bit mdv, input int mda);
    IdValid = v; IdRs1Addr = 5'(rs1); IdRs1ReadEnable = r1e;
    IdRs2Addr = 5'(rs2); IdRs2ReadEnable = r2e; IdRdAddr = 5'(rd);
    IdIsLoad = ld; IdIsMulDiv = md; Flush = fl;
    LoadDoneValid = ldv; LoadDoneAddr = 5'(lda); MulDoneValid = mdv; MulDoneAddr = 5'(mda);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check the combinational stall, advance the model, check registered state.
  task automatic cycle(input string tag);
    bit issue;
    #1;
    m_haz = IdValid && !Flush &&
            ((IdRs1ReadEnable && blocked(int'(IdRs1Addr))) ||
             (IdRs2ReadEnable && blocked(int'(IdRs2Addr))) ||
             ((IdIsLoad || IdIsMulDiv) && blocked(int'(IdRdAddr))) ||
             (IdIsMulDiv && m_busy && !MulDoneValid));
    chk({tag, ".stall"}, 64'(StallId), 64'(m_haz));
    chk({tag, ".bubble"}, 64'(BubbleOut), 64'(m_haz));
    issue = IdValid && !Flush && !m_haz;
    if (LoadDoneValid && !m_pend[LoadDoneAddr]) m_err = 1;
    if (MulDoneValid && !m_pend[MulDoneAddr]) m_err = 1;
    if (LoadDoneValid) m_pend[LoadDoneAddr] = 0;
    if (MulDoneValid) m_pend[MulDoneAddr] = 0;
    if (issue && (IdIsLoad || IdIsMulDiv) && IdRdAddr != 0) m_pend[IdRdAddr] = 1;
    if (issue && IdIsMulDiv) m_busy = 1;
    else if (MulDoneValid) m_busy = 0;
    if (m_haz && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    @(posedge Clk);
    #1;
    chk({tag, ".pending"}, 64'(PendingOut), 64'(model_vec()));
    chk({tag, ".mulbusy"}, 64'(MulBusy), 64'(m_busy));
    chk({tag, ".stallcnt"}, 64'(StallCount), 64'(m_cnt));
    chk({tag, ".sberror"}, 64'(SbError), 64'(m_err));
    $display("[%0t] %s stall=%0b pend=%08h busy=%0b cnt=%0d err=%0b",
             $time, tag, m_haz, PendingOut, MulBusy, StallCount, SbError);
    @(negedge Clk);
  endtask

  initial begin
    int lda, mda, pick;
    Rst = 1'b0;
    idle();
    model_reset();
    #2;
    chk("reset.pending", 64'(PendingOut), 64'h0);
    chk("reset.mulbusy", 64'(MulBusy), 64'h0);
    chk("reset.stallcnt", 64'(StallCount), 64'h0);
    chk("reset.sberror", 64'(SbError), 64'h0);
    chk("reset.stall", 64'(StallId), 64'h0);
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;

    // Load-use: two stalled cycles, then the done cycle frees it immediately.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0); cycle("ld_issue");
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0); cycle("ld_use_stall1");
    chk("ld_use.stall_const", 64'(StallCount), 64'd1);
    cycle("ld_use_stall2");
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 1, 5, 0, 0); cycle("ld_use_done");
    chk("ld_use.pending5", 64'(PendingOut[5]), 64'h0);
    chk("ld_use.count", 64'(StallCount), 64'd2);

    // x0 never becomes pending nor stalls.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("x0_load");
    drive(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle("x0_read");

    // Mul structural hazard; div issues in the mul done cycle.
    drive(1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0); cycle("mul_issue");
    drive(1, 1, 1, 2, 1, 8, 0, 1, 0, 0, 0, 0, 0); cycle("div_stall1");
    cycle("div_stall2");
    drive(1, 1, 1, 2, 1, 8, 0, 1, 0, 0, 0, 1, 7); cycle("div_issue");
    chk("mul.pending_bit8", 64'(PendingOut), 64'h100);
    chk("mul.busy_kept", 64'(MulBusy), 64'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8); cycle("div_done");

    // Same-cycle clear and set of rd=9: set wins.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0); cycle("ld9_a");
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 9, 0, 0); cycle("ld9_b");
    chk("setwins.pending9", 64'(PendingOut[9]), 64'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); cycle("ld9_done");

    // Flush hides a RAW hazard and leaves Pending alone.
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0); cycle("ld3");
    drive(1, 0, 0, 3, 1, 4, 1, 0, 1, 0, 0, 0, 0); cycle("flush_raw");
    chk("flush.pending", 64'(PendingOut), 64'h8);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); cycle("ld3_done");

    // Spurious completion sets the sticky error.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12); cycle("spurious_mul");
    idle(); cycle("err_sticky1"); cycle("err_sticky2");
    chk("sberror.sticky", 64'(SbError), 64'h1);

    // Asynchronous reset mid-cycle with Pending[4] and MulBusy set.
    drive(1, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0); cycle("mul4");
    idle();
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    chk("arst.pending", 64'(PendingOut), 64'h0);
    chk("arst.mulbusy", 64'(MulBusy), 64'h0);
    chk("arst.stallcnt", 64'(StallCount), 64'h0);
    chk("arst.sberror", 64'(SbError), 64'h0);
    chk("arst.stall", 64'(StallId), 64'h0);
    @(negedge Clk);
    Rst = 1'b1;

    // Randomized traffic; completions mostly target genuinely pending registers.
    for (int n = 0; n < 400; n++) begin
      lda = 0; mda = 0;
      pick = int'($urandom_range(1, 7));
      if (m_pend[pick]) lda = pick;
      pick = int'($urandom_range(1, 7));
      if (m_pend[pick]) mda = pick;
      if ($urandom_range(0, 19) == 0) lda = int'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            (lda != 0 || pick == 0) && $urandom_range(0, 2) != 0, lda,
            (mda != 0) && m_busy && $urandom_range(0, 2) != 0, mda);
      cycle($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
